legup_arg_mem_slave: RTL and testbench

LEGUP_ARG_MEM_SLAVE -- requirements
Module: legup_arg_mem_slave

---
 rtl/legup_arg_mem_slave.sv | 206 ++++++++++++++++++++
 tb/tb_legup_arg_mem_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/legup_arg_mem_slave.sv
// Purpose: word-addressed argument memory behind an Avalon-MM style slave port with per-transfer wait states.
// Latency: a request accepted in IDLE is acknowledged WAIT_CYCLES+1 cycles later (waitrequest low for one cycle).
// Backpressure: waitrequest is high whenever a request is present and the FSM is not in ACK.
module legup_arg_mem_slave #(
    parameter int BUS_SIZE    = 64,
    parameter int BUS_BYTES   = BUS_SIZE / 8,
    parameter int ADDR_W      = 13,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [ADDR_W-1:0]    avs_address,
    input  logic [BUS_SIZE-1:0]  avs_writedata,
    input  logic [BUS_BYTES-1:0] avs_byteenable,
    output logic [BUS_SIZE-1:0]  avs_readdata,
    output logic                 avs_waitrequest,
    output logic                 err,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);

    // Word index drops the three byte-offset bits of the address.
    localparam int IDX_W  = ADDR_W - 3;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Parameter sanity: elaboration fails loudly on an inconsistent configuration.
    generate
        if (BUS_BYTES * 8 != BUS_SIZE) begin : g_bad_bytes
            $error("BUS_BYTES must equal BUS_SIZE/8");
        end
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("WAIT_CYCLES must be in 0..15");
        end
        if (ADDR_W < 4) begin : g_bad_addr
            $error("ADDR_W must be at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Transfer captured when a request is accepted in IDLE.
    typedef struct packed {
        logic [IDX_W-1:0]     idx;
        logic [BUS_SIZE-1:0]  wdata;
        logic [BUS_BYTES-1:0] be;
        logic                 is_wr;
    } req_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    req_t                  req_q, req_d;
    logic [BUS_SIZE-1:0]   rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic                  mem_we;
    logic                  req_present;
    logic                  in_range_q;
    logic [MEM_AW-1:0]     mem_idx_q;
    logic [MEM_AW-1:0]     mem_idx_d;
    logic                  unused_addr_lsbs;

    logic [BUS_SIZE-1:0]   mem [DEPTH];

    // A word index beyond the array is legal on the bus but never touches storage.
    function automatic logic idx_ok(input logic [IDX_W-1:0] i);
        return (32'(i) < DEPTH);
    endfunction

    assign req_present      = avs_read | avs_write;
    assign unused_addr_lsbs = ^avs_address[2:0];
    assign in_range_q       = idx_ok(req_q.idx);
    assign mem_idx_q        = MEM_AW'(req_q.idx);
    assign mem_idx_d        = MEM_AW'(req_d.idx);

    // Stall the master until the single ACK cycle of the current transfer.
    assign avs_waitrequest = req_present & (state_q != ACK);

    assign avs_readdata = rdata_q;
    assign err          = err_q;
    assign rd_count     = rd_cnt_q;
    assign wr_count     = wr_cnt_q;

    // Next-state logic: accept, count wait states, complete, and flag protocol/range errors.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_present) begin
                    req_d.idx   = avs_address[ADDR_W-1:3];
                    req_d.wdata = avs_writedata;
                    req_d.be    = avs_byteenable;
                    // A simultaneous read and write is resolved as a write.
                    req_d.is_wr = avs_write;
                    if (avs_read && avs_write) begin
                        err_d = 1'b1;
                    end
                    if (!idx_ok(avs_address[ADDR_W-1:3])) begin
                        err_d = 1'b1;
                    end
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end

            WAIT: begin
                if (!req_present) begin
                    // Master abandoned the transfer: no update, no count.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    err_d   = 1'b1;
                end else begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                    // The value loaded on entry equals the number of WAIT cycles spent.
                    if (cnt_q <= 4'd1) begin
                        state_d = ACK;
                    end
                end
            end

            ACK: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                if (req_q.is_wr) begin
                    mem_we = in_range_q & ~reset;
                    if (wr_cnt_q != 16'hFFFF) begin
                        wr_cnt_d = wr_cnt_q + 16'd1;
                    end
                end else begin
                    if (rd_cnt_q != 16'hFFFF) begin
                        rd_cnt_d = rd_cnt_q + 16'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // Read data is captured on the edge that enters ACK and held until the next read.
        if (state_d == ACK && state_q != ACK && !req_d.is_wr) begin
            if (idx_ok(req_d.idx)) begin
                rdata_d = mem[mem_idx_d];
            end else begin
                rdata_d = '0;
            end
        end
    end

    // Control and status registers; reset aborts any transfer in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            req_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Storage array: byte-masked write in the ACK cycle; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < BUS_BYTES; b++) begin
                if (req_q.be[b]) begin
                    mem[mem_idx_q][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_legup_arg_mem_slave.sv
// Purpose: scoreboard bench for two slave instances (2 wait states, and 0 wait states with a wider address).
// Latency: each transfer is expected to acknowledge WAIT_CYCLES+1 cycles after it is presented.
// Backpressure: requests are held until waitrequest drops, then released or replaced back-to-back.
module tb_legup_arg_mem_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [63:0] rdata_a, rdata_b;
    logic        wq_a, wq_b, err_a, err_b;
    logic [15:0] rc_a, wc_a, rc_b, wc_b;

    always #5 clk = ~clk;

    legup_arg_mem_slave #(
        .BUS_SIZE(64), .BUS_BYTES(8), .ADDR_W(13), .DEPTH(1024), .WAIT_CYCLES(2)
    ) u_dut_a (
        .clk(clk), .reset(reset), .avs_read(rd_a), .avs_write(wr_a),
        .avs_address(addr[12:0]), .avs_writedata(wdata), .avs_byteenable(be),
        .avs_readdata(rdata_a), .avs_waitrequest(wq_a), .err(err_a),
        .rd_count(rc_a), .wr_count(wc_a)
    );

    legup_arg_mem_slave #(
        .BUS_SIZE(64), .BUS_BYTES(8), .ADDR_W(14), .DEPTH(1024), .WAIT_CYCLES(0)
    ) u_dut_b (
        .clk(clk), .reset(reset), .avs_read(rd_b), .avs_write(wr_b),
        .avs_address(addr), .avs_writedata(wdata), .avs_byteenable(be),
        .avs_readdata(rdata_b), .avs_waitrequest(wq_b), .err(err_b),
        .rd_count(rc_b), .wr_count(wc_b)
    );

    typedef struct {
        bit          is_rd;
        logic [63:0] data;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor for instance A: every acknowledged transfer pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (rd_a || wr_a) && !wq_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_ack: got ack with empty queue, expected none");
            end else begin
                e = q_a.pop_front();
                if (e.is_rd) chk("a_readdata", rdata_a, e.data);
            end
        end
    end

    // Monitor for instance B.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (rd_b || wr_b) && !wq_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_ack: got ack with empty queue, expected none");
            end else begin
                e = q_b.pop_front();
                if (e.is_rd) chk("b_readdata", rdata_b, e.data);
            end
        end
    end

    // Present one transfer, wait (bounded) for its ACK cycle, check the stall length.
    // Returns just after the ACK edge with the request still asserted.
    task automatic xfer(input bit b, input bit r, input bit w, input logic [13:0] a,
                        input logic [63:0] d, input logic [7:0] e_be, input bit push_rd,
                        input logic [63:0] exp_rd, input int exp_lat, input string name);
        int   cyc;
        bit   ack;
        exp_t x;
        x.is_rd = push_rd;
        x.data  = exp_rd;
        if (b) q_b.push_back(x);
        else   q_a.push_back(x);
        addr  = a;
        wdata = d;
        be    = e_be;
        if (b) begin rd_b = r; wr_b = w; end
        else   begin rd_a = r; wr_a = w; end
        cyc = 0;
        ack = 1'b0;
        while (!ack && cyc < 40) begin
            @(negedge clk);
            cyc++;
            ack = b ? !wq_b : !wq_a;
            @(posedge clk);
            #1;
        end
        chk({name, "_latency"}, 64'(cyc - 1), 64'(exp_lat));
    endtask

    task automatic idle();
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        addr = '0; wdata = '0; be = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("a_rst_readdata", rdata_a, 64'h0);
        chk("a_rst_err", 64'(err_a), 64'h0);
        chk("a_rst_rd_count", 64'(rc_a), 64'h0);
        chk("a_rst_wr_count", 64'(wc_a), 64'h0);
        chk("a_rst_waitreq", 64'(wq_a), 64'h0);
        chk("b_rst_readdata", rdata_b, 64'h0);
        chk("b_rst_err", 64'(err_b), 64'h0);
        @(posedge clk);
        #1;

        // Instance A, 2 wait states: full write then readback.
        xfer(0, 0, 1, 14'h010, 64'h1122334455667788, 8'hFF, 0, 64'h0, 3, "a_wr1");
        idle();
        xfer(0, 1, 0, 14'h010, 64'h0, 8'h00, 1, 64'h1122334455667788, 3, "a_rd1");
        idle();
        chk("a_wr_count_1", 64'(wc_a), 64'd1);
        chk("a_rd_count_1", 64'(rc_a), 64'd1);
        chk("a_err_clean", 64'(err_a), 64'h0);

        // Low-half byte-masked write.
        xfer(0, 0, 1, 14'h010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 64'h0, 3, "a_wr2");
        idle();
        xfer(0, 1, 0, 14'h010, 64'h0, 8'h00, 1, 64'h11223344AAAAAAAA, 3, "a_rd2");
        idle();
        chk("a_wr_count_2", 64'(wc_a), 64'd2);
        chk("a_rd_count_2", 64'(rc_a), 64'd2);

        // Reset in the middle of a write's wait states.
        addr = 14'h010; wdata = 64'hDEADBEEFDEADBEEF; be = 8'hFF; wr_a = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("a_wait_stall", 64'(wq_a), 64'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        wr_a  = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("a_abort_rd_count", 64'(rc_a), 64'h0);
        chk("a_abort_wr_count", 64'(wc_a), 64'h0);
        chk("a_abort_err", 64'(err_a), 64'h0);
        chk("a_abort_readdata", rdata_a, 64'h0);
        @(posedge clk);
        #1;
        xfer(0, 1, 0, 14'h010, 64'h0, 8'h00, 1, 64'h11223344AAAAAAAA, 3, "a_rd_after_abort");
        idle();
        chk("a_rd_count_3", 64'(rc_a), 64'd1);
        chk("a_wr_count_3", 64'(wc_a), 64'd0);

        // Read dropped during WAIT.
        addr = 14'h010; rd_a = 1'b1;
        @(posedge clk);
        #1;
        rd_a = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("a_drop_err", 64'(err_a), 64'h1);
        chk("a_drop_rd_count", 64'(rc_a), 64'd1);
        @(posedge clk);
        #1;
        xfer(0, 1, 0, 14'h010, 64'h0, 8'h00, 1, 64'h11223344AAAAAAAA, 3, "a_rd_after_drop");
        idle();
        chk("a_rd_count_4", 64'(rc_a), 64'd2);
        chk("a_err_sticky", 64'(err_a), 64'h1);

        // Instance B, no wait states: seed three words, then back-to-back reads.
        xfer(1, 0, 1, 14'h000, 64'h0101010101010101, 8'hFF, 0, 64'h0, 1, "b_wr0");
        idle();
        xfer(1, 0, 1, 14'h008, 64'h0202020202020202, 8'hFF, 0, 64'h0, 1, "b_wr1");
        idle();
        xfer(1, 0, 1, 14'h010, 64'h0303030303030303, 8'hFF, 0, 64'h0, 1, "b_wr2");
        idle();
        xfer(1, 1, 0, 14'h000, 64'h0, 8'h00, 1, 64'h0101010101010101, 1, "b_b2b0");
        xfer(1, 1, 0, 14'h008, 64'h0, 8'h00, 1, 64'h0202020202020202, 1, "b_b2b1");
        xfer(1, 1, 0, 14'h010, 64'h0, 8'h00, 1, 64'h0303030303030303, 1, "b_b2b2");
        idle();
        chk("b_wr_count_1", 64'(wc_b), 64'd3);
        chk("b_rd_count_1", 64'(rc_b), 64'd3);
        chk("b_err_clean", 64'(err_b), 64'h0);

        // Read and write together: treated as a write, flagged.
        xfer(1, 1, 1, 14'h018, 64'h5555555555555555, 8'hFF, 0, 64'h0, 1, "b_rw");
        idle();
        chk("b_rw_err", 64'(err_b), 64'h1);
        chk("b_rw_wr_count", 64'(wc_b), 64'd4);
        chk("b_rw_rd_count", 64'(rc_b), 64'd3);
        xfer(1, 1, 0, 14'h018, 64'h0, 8'h00, 1, 64'h5555555555555555, 1, "b_rd_rw");
        idle();

        // Word index 1024: write discarded, read returns zero, word 0 not aliased.
        xfer(1, 0, 1, 14'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 0, 64'h0, 1, "b_oor_wr");
        idle();
        xfer(1, 1, 0, 14'h2000, 64'h0, 8'h00, 1, 64'h0, 1, "b_oor_rd");
        idle();
        xfer(1, 1, 0, 14'h000, 64'h0, 8'h00, 1, 64'h0101010101010101, 1, "b_no_alias");
        idle();
        chk("b_wr_count_2", 64'(wc_b), 64'd5);
        chk("b_rd_count_2", 64'(rc_b), 64'd6);
        chk("b_err_final", 64'(err_b), 64'h1);

        repeat (2) @(posedge clk);
        chk("a_queue_empty", 64'(q_a.size()), 64'd0);
        chk("b_queue_empty", 64'(q_b.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
